// File: rtl/vanilla_dma_desc_sched.sv
// In-order DMA descriptor scheduler: queues jobs, programs the engine's four control words, reports tagged completions.
// Optional BUSY watchdog: define VANILLA_DMA_SCHED_WATCHDOG_EN.
//
// state  | meaning
// IDLE   | wait for a queued descriptor while halt_i is low, then pop it
// WR_LOC | write local address (0x00)
// WR_REM | write remote address (0x04)
// WR_LEN | write length (0x08)
// WR_CTL | write control word with go (0x0C)
// BUSY   | wait for engine done after blanking (or watchdog expiry)
// DONE   | one-cycle completion pulse
module vanilla_dma_desc_sched #(
  parameter int els_p            = 4,
  parameter int tag_width_p      = 4,
  parameter int timeout_cycles_p = 4096
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     desc_v_i,
  output logic                     desc_ready_o,
  input  logic [11:0]              desc_local_addr_i,
  input  logic [31:0]              desc_remote_addr_i,
  input  logic [11:0]              desc_num_bytes_i,
  input  logic                     desc_push_not_pull_i,
  input  logic [4:0]               desc_rd_id_i,
  input  logic [11:0]              desc_wb_addr_i,
  input  logic [tag_width_p-1:0]   desc_tag_i,
  input  logic                     halt_i,
  output logic                     cfg_v_o,
  output logic [4:0]               cfg_addr_o,
  output logic [31:0]              cfg_data_o,
  input  logic                     cfg_ready_i,
  input  logic                     dma_done_i,
  output logic                     cmpl_v_o,
  output logic [tag_width_p-1:0]   cmpl_tag_o,
  output logic                     cmpl_err_o,
  output logic                     busy_o,
  output logic [$clog2(els_p):0]   pending_o
);

  localparam int lg_els_lp = $clog2(els_p);

  if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
    $error("els_p must be a power of 2 and at least 2");
  end
  if (timeout_cycles_p < 2) begin : g_bad_timeout
    $error("timeout_cycles_p must be at least 2");
  end

  typedef struct packed {
    logic [tag_width_p-1:0] tag;
    logic [11:0]            wb_addr;
    logic [4:0]             rd_id;
    logic                   push_not_pull;
    logic [11:0]            num_bytes;
    logic [31:0]            remote_addr;
    logic [11:0]            local_addr;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LOC, S_WR_REM, S_WR_LEN, S_WR_CTL, S_BUSY, S_DONE
  } state_e;

  desc_t                r_mem [els_p];
  desc_t                r_act;
  desc_t                w_desc_in;
  desc_t                w_head;
  logic [lg_els_lp-1:0] r_wr_ptr;
  logic [lg_els_lp-1:0] r_rd_ptr;
  logic [lg_els_lp:0]   r_count;
  state_e               r_state;
  state_e               w_state_nxt;
  logic [1:0]           r_blank;
  logic                 w_enq;
  logic                 w_deq;
  logic                 w_go;
  logic                 w_done_ok;
  logic                 w_timeout;

  assign w_desc_in = '{tag: desc_tag_i, wb_addr: desc_wb_addr_i, rd_id: desc_rd_id_i,
                       push_not_pull: desc_push_not_pull_i, num_bytes: desc_num_bytes_i,
                       remote_addr: desc_remote_addr_i, local_addr: desc_local_addr_i};
  assign w_head    = r_mem[r_rd_ptr];

  // Ready comes from the registered count only, so a full queue never accepts even when popping.
  assign desc_ready_o = (r_count != (lg_els_lp + 1)'(els_p));
  assign w_enq        = desc_v_i & desc_ready_o;
  assign w_deq        = (r_state == S_IDLE) & (r_count != '0) & ~halt_i;
  assign w_go         = (r_state == S_WR_CTL) & cfg_ready_i;
  assign w_done_ok    = (r_blank == 2'd0) & dma_done_i;

  assign pending_o  = r_count;
  assign busy_o     = (r_state != S_IDLE);
  assign cmpl_v_o   = (r_state == S_DONE);
  assign cmpl_tag_o = r_act.tag;

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wr_ptr] <= w_desc_in;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= S_IDLE;
      r_act    <= '0;
      r_blank  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_act    <= w_head;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // Blanking hides a done level left over from the previous job.
      if (w_go) r_blank <= 2'd2;
      else if (r_state == S_BUSY && r_blank != 2'd0) r_blank <= r_blank - 2'd1;
    end
  end

`ifdef VANILLA_DMA_SCHED_WATCHDOG_EN
  localparam int wd_w_lp = (timeout_cycles_p > 2) ? $clog2(timeout_cycles_p) : 1;
  logic [wd_w_lp-1:0] r_wd;
  logic               r_err;

  assign w_timeout  = (r_state == S_BUSY) && (r_wd == wd_w_lp'(timeout_cycles_p - 1));
  assign cmpl_err_o = (r_state == S_DONE) & r_err;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_go) r_wd <= '0;
      else if (r_state == S_BUSY) r_wd <= r_wd + 1'b1;
      if (r_state == S_BUSY) r_err <= w_timeout & ~w_done_ok;
      else if (r_state == S_DONE) r_err <= 1'b0;
    end
  end
`else
  assign w_timeout  = 1'b0;
  assign cmpl_err_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    cfg_v_o     = 1'b0;
    cfg_addr_o  = 5'h00;
    cfg_data_o  = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_deq) w_state_nxt = (w_head.num_bytes == 12'd0) ? S_DONE : S_WR_LOC;
      end
      S_WR_LOC: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = 5'h00;
        cfg_data_o = {20'b0, r_act.local_addr};
        if (cfg_ready_i) w_state_nxt = S_WR_REM;
      end
      S_WR_REM: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = 5'h04;
        cfg_data_o = r_act.remote_addr;
        if (cfg_ready_i) w_state_nxt = S_WR_LEN;
      end
      S_WR_LEN: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = 5'h08;
        cfg_data_o = {20'b0, r_act.num_bytes};
        if (cfg_ready_i) w_state_nxt = S_WR_CTL;
      end
      S_WR_CTL: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = 5'h0C;
        cfg_data_o = {4'b0, r_act.wb_addr, 7'b0, r_act.rd_id, 1'b0, r_act.push_not_pull, 1'b0, 1'b1};
        if (cfg_ready_i) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (w_done_ok || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vanilla_dma_desc_sched.sv
// Bench for vanilla_dma_desc_sched: directed plus randomized jobs against a job-level reference model.
// Watchdog checks are included when VANILLA_DMA_SCHED_WATCHDOG_EN is defined.
module tb_vanilla_dma_desc_sched;

  localparam int TO = 16;
`ifdef VANILLA_DMA_SCHED_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        desc_v_i;
  logic        desc_ready_o;
  logic [11:0] desc_local_addr_i;
  logic [31:0] desc_remote_addr_i;
  logic [11:0] desc_num_bytes_i;
  logic        desc_push_not_pull_i;
  logic [4:0]  desc_rd_id_i;
  logic [11:0] desc_wb_addr_i;
  logic [3:0]  desc_tag_i;
  logic        halt_i;
  logic        cfg_v_o;
  logic [4:0]  cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        cfg_ready_i;
  logic        dma_done_i;
  logic        cmpl_v_o;
  logic [3:0]  cmpl_tag_o;
  logic        cmpl_err_o;
  logic        busy_o;
  logic [2:0]  pending_o;

  vanilla_dma_desc_sched #(.els_p(4), .tag_width_p(4), .timeout_cycles_p(TO)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .desc_v_i(desc_v_i), .desc_ready_o(desc_ready_o),
    .desc_local_addr_i(desc_local_addr_i), .desc_remote_addr_i(desc_remote_addr_i),
    .desc_num_bytes_i(desc_num_bytes_i), .desc_push_not_pull_i(desc_push_not_pull_i),
    .desc_rd_id_i(desc_rd_id_i), .desc_wb_addr_i(desc_wb_addr_i), .desc_tag_i(desc_tag_i),
    .halt_i(halt_i), .cfg_v_o(cfg_v_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_ready_i(cfg_ready_i), .dma_done_i(dma_done_i), .cmpl_v_o(cmpl_v_o),
    .cmpl_tag_o(cmpl_tag_o), .cmpl_err_o(cmpl_err_o), .busy_o(busy_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [11:0] loc;
    logic [31:0] rem;
    logic [11:0] len;
    logic        pnp;
    logic [4:0]  rd;
    logic [11:0] wb;
    logic [3:0]  tag;
  } desc_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  desc_t exp_q[$];
  desc_t cur;
  bit    have_cur = 0;
  int    wr_idx = 0;
  bit    in_busy = 0;
  int    bk = 0;
  bit    cmpl_due = 0;
  bit    due_err = 0;
  int    cyc = 0;
  int    go_cyc = 0, first_wr_cyc = 0, cmpl_cyc = 0, enq_cyc = 0;
  int    n_cmpl = 0, n_wr = 0;
  logic [31:0] last_ctl_data = '0;
  logic        last_err = 1'b0;

  // engine model controls
  int ready_mode = 0;   // 0 always ready, 1 toggle, 2 random
  int done_mode  = 0;   // 0 done after delay, 1 stuck high, 2 never
  int done_delay = 0;
  int done_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(desc_t d, int idx);
    case (idx)
      0:       return 32'(d.loc);
      1:       return d.rem;
      2:       return 32'(d.len);
      default: return (32'(d.wb) << 16) | (32'(d.rd) << 4) | (32'(d.pnp) << 2) | 32'd1;
    endcase
  endfunction

  function automatic desc_t rand_desc(bit allow_zero);
    desc_t d;
    d.loc = 12'($urandom);
    d.rem = $urandom;
    d.len = 12'($urandom_range(1, 4095));
    if (allow_zero && $urandom_range(0, 3) == 0) d.len = 12'd0;
    d.pnp = 1'($urandom);
    d.rd  = 5'($urandom);
    d.wb  = 12'($urandom);
    d.tag = 4'($urandom);
    return d;
  endfunction

  // Engine responder plus job-level scoreboard, one sample per cycle just after the falling edge.
  initial begin
    cfg_ready_i = 1'b1;
    dma_done_i  = 1'b1;
    forever begin
      @(negedge clk_i);
      cyc++;
      case (ready_mode)
        0:       cfg_ready_i = 1'b1;
        1:       cfg_ready_i = ~cfg_ready_i;
        default: cfg_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (done_mode == 1) dma_done_i = 1'b1;
      else if (done_mode == 2) dma_done_i = 1'b0;
      else if (done_cnt > 0) begin
        dma_done_i = 1'b0;
        done_cnt--;
      end else dma_done_i = 1'b1;
      #1;
      if (!reset_n_i) begin
        exp_q.delete();
        have_cur = 0; in_busy = 0; cmpl_due = 0; wr_idx = 0;
      end else begin
        if (cmpl_v_o) begin
          if (!have_cur) begin
            if (exp_q.size() == 0) chk("cmpl_unexpected", 32'(cmpl_v_o), 32'd0);
            else begin
              cur = exp_q.pop_front();
              chk("cmpl_zero_len_job", 32'(cur.len), 32'd0);
              chk("cmpl_tag", 32'(cmpl_tag_o), 32'(cur.tag));
              chk("cmpl_err", 32'(cmpl_err_o), 32'd0);
            end
          end else begin
            chk("cmpl_early", 32'(cmpl_v_o), 32'(cmpl_due));
            chk("cmpl_tag", 32'(cmpl_tag_o), 32'(cur.tag));
            chk("cmpl_err", 32'(cmpl_err_o), 32'(due_err));
          end
          have_cur = 0;
          cmpl_cyc = cyc;
          last_err = cmpl_err_o;
          n_cmpl++;
        end else if (cmpl_due) chk("cmpl_missing", 32'(cmpl_v_o), 32'd1);
        cmpl_due = 0;

        if (in_busy) begin
          chk("busy_o_in_busy", 32'(busy_o), 32'd1);
          if (bk >= 2 && dma_done_i) begin
            cmpl_due = 1; due_err = 0; in_busy = 0;
          end else if (WD && bk == TO - 1) begin
            cmpl_due = 1; due_err = 1; in_busy = 0;
          end else bk++;
        end

        if (cfg_v_o) begin
          if (!have_cur) begin
            if (exp_q.size() == 0) chk("cfg_unexpected", 32'(cfg_v_o), 32'd0);
            else begin
              cur = exp_q.pop_front();
              have_cur = 1;
              wr_idx = 0;
              first_wr_cyc = cyc;
              chk("cfg_job_nonzero_len", 32'(cur.len != 12'd0), 32'd1);
            end
          end
          if (have_cur) begin
            chk("cfg_write_count", 32'(wr_idx < 4), 32'd1);
            chk("cfg_addr", 32'(cfg_addr_o), 32'(wr_idx * 4));
            chk("cfg_data", cfg_data_o, exp_data(cur, wr_idx));
            if (cfg_ready_i && wr_idx < 4) begin
              wr_idx++;
              n_wr++;
              if (wr_idx == 4) begin
                in_busy = 1; bk = 0; go_cyc = cyc;
                last_ctl_data = cfg_data_o;
                done_cnt = done_delay;
              end
            end
          end
        end

        if (desc_v_i && desc_ready_o) begin
          exp_q.push_back('{loc: desc_local_addr_i, rem: desc_remote_addr_i, len: desc_num_bytes_i,
                            pnp: desc_push_not_pull_i, rd: desc_rd_id_i, wb: desc_wb_addr_i,
                            tag: desc_tag_i});
          enq_cyc = cyc;
        end
      end
    end
  end

  task automatic push(input desc_t d);
    int n;
    @(negedge clk_i);
    desc_local_addr_i    = d.loc;
    desc_remote_addr_i   = d.rem;
    desc_num_bytes_i     = d.len;
    desc_push_not_pull_i = d.pnp;
    desc_rd_id_i         = d.rd;
    desc_wb_addr_i       = d.wb;
    desc_tag_i           = d.tag;
    desc_v_i             = 1'b1;
    n = 0;
    while (!desc_ready_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 3000) chk("push_ready_timeout", 32'(desc_ready_o), 32'd1);
    @(negedge clk_i);
    desc_v_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok;
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      #2;
      if (!have_cur && exp_q.size() == 0 && !busy_o && !desc_v_i && pending_o == 3'd0) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle_timeout", 32'(busy_o | !ok), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global time limit");
  end

  initial begin
    desc_t d;
    int    base;
    int    n;
    reset_n_i = 1'b0; desc_v_i = 1'b0; halt_i = 1'b0;
    desc_local_addr_i = '0; desc_remote_addr_i = '0; desc_num_bytes_i = '0;
    desc_push_not_pull_i = 1'b0; desc_rd_id_i = '0; desc_wb_addr_i = '0; desc_tag_i = '0;
    #22;
    chk("rst_desc_ready", 32'(desc_ready_o), 32'd1);
    chk("rst_cfg_v", 32'(cfg_v_o), 32'd0);
    chk("rst_cfg_addr", 32'(cfg_addr_o), 32'd0);
    chk("rst_cfg_data", cfg_data_o, 32'd0);
    chk("rst_cmpl_v", 32'(cmpl_v_o), 32'd0);
    chk("rst_cmpl_tag", 32'(cmpl_tag_o), 32'd0);
    chk("rst_cmpl_err", 32'(cmpl_err_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pending", 32'(pending_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // single directed push job
    done_delay = 20;
    d = '{loc: 12'h100, rem: 32'h2000_0040, len: 12'd64, pnp: 1'b1, rd: 5'd10, wb: 12'h3FC, tag: 4'd5};
    push(d);
    wait_idle(200);
    chk("single_consecutive_writes", 32'(go_cyc - first_wr_cyc), 32'd3);
    chk("single_ctl_word", last_ctl_data, 32'h03FC_00A5);
    chk("single_cmpl_count", 32'(n_cmpl), 32'd1);

    // halt holds jobs in the queue; fifth descriptor is held off
    halt_i = 1'b1;
    done_delay = 3;
    base = n_cmpl;
    for (int i = 0; i < 4; i++) begin
      d = rand_desc(0);
      d.tag = 4'(i + 1);
      push(d);
    end
    d = rand_desc(0);
    d.tag = 4'd9;
    @(negedge clk_i);
    desc_local_addr_i = d.loc; desc_remote_addr_i = d.rem; desc_num_bytes_i = d.len;
    desc_push_not_pull_i = d.pnp; desc_rd_id_i = d.rd; desc_wb_addr_i = d.wb; desc_tag_i = d.tag;
    desc_v_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #2;
    chk("full_ready_low", 32'(desc_ready_o), 32'd0);
    chk("full_pending", 32'(pending_o), 32'd4);
    chk("halt_not_busy", 32'(busy_o), 32'd0);
    halt_i = 1'b0;
    n = 0;
    while (!desc_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("full_ready_return", 32'(desc_ready_o), 32'd1);
    @(negedge clk_i);
    desc_v_i = 1'b0;
    wait_idle(1000);
    chk("halt_cmpl_count", 32'(n_cmpl - base), 32'd5);

    // cfg_ready toggling
    ready_mode = 1;
    base = n_wr;
    for (int i = 0; i < 3; i++) push(rand_desc(0));
    wait_idle(1000);
    chk("toggle_write_count", 32'(n_wr - base), 32'd12);

    // stale done level held high across jobs
    ready_mode = 0;
    done_mode = 1;
    for (int i = 0; i < 2; i++) push(rand_desc(0));
    wait_idle(500);
    done_mode = 0;

    // zero-length job
    base = n_wr;
    d = rand_desc(0);
    d.len = 12'd0;
    d.tag = 4'd3;
    push(d);
    wait_idle(100);
    chk("zero_len_latency", 32'(cmpl_cyc - enq_cyc), 32'd2);
    chk("zero_len_no_cfg", 32'(n_wr - base), 32'd0);

    // randomized back-to-back jobs
    base = n_cmpl;
    for (int i = 0; i < 12; i++) begin
      ready_mode = $urandom_range(0, 2);
      done_mode  = $urandom_range(0, 1);
      done_delay = $urandom_range(0, 8);
      push(rand_desc(1));
    end
    wait_idle(5000);
    chk("random_cmpl_count", 32'(n_cmpl - base), 32'd12);
    ready_mode = 0;
    done_mode = 0;

    if (WD) begin
      done_mode = 2;
      push(rand_desc(0));
      wait_idle(200);
      chk("wd_latency", 32'(cmpl_cyc - (go_cyc + 1)), 32'(TO));
      chk("wd_err", 32'(last_err), 32'd1);
      done_mode = 0;
    end

    // asynchronous reset while BUSY with one job pending
    done_mode = 2;
    push(rand_desc(0));
    push(rand_desc(0));
    n = 0;
    while (!(in_busy && bk >= 3) && n < 200) begin
      @(negedge clk_i);
      #2;
      n++;
    end
    chk("pre_reset_busy", 32'(busy_o), 32'd1);
    chk("pre_reset_pending", 32'(pending_o), 32'd1);
    #1;
    reset_n_i = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    chk("async_rst_pending", 32'(pending_o), 32'd0);
    chk("async_rst_ready", 32'(desc_ready_o), 32'd1);
    chk("async_rst_cfg_v", 32'(cfg_v_o), 32'd0);
    chk("async_rst_cmpl_v", 32'(cmpl_v_o), 32'd0);
    chk("async_rst_tag", 32'(cmpl_tag_o), 32'd0);
    chk("async_rst_err", 32'(cmpl_err_o), 32'd0);
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    done_mode = 0;
    done_delay = 2;
    base = n_cmpl;
    push(rand_desc(0));
    wait_idle(200);
    chk("post_reset_cmpl_count", 32'(n_cmpl - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vanilla_dma_desc_sched.md
Name: vanilla_dma_desc_sched

Overview:
- Descriptor scheduler that sequences the tile-local DMA engine.
- Accepts DMA job descriptors from a requester into a small queue, then processes them strictly in order:
  - programs the four engine control words (0x0 local addr, 0x4 remote addr, 0x8 length, 0xC control/go);
  - waits for engine completion;
  - reports a tagged completion.
- Lets software post several transfers back-to-back instead of polling between each one.

Parameters:
- els_p, 4: descriptor queue depth; must be a power of 2, ≥ 2.
- tag_width_p, 4: width of the requester-supplied job tag returned on completion.
- timeout_cycles_p, 4096: watchdog limit in BUSY; used only when the optional feature is enabled.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- desc_v_i  in  1  descriptor valid
- desc_ready_o  out  1  queue not full
- desc_local_addr_i  in  12  local dmem byte address
- desc_remote_addr_i  in  32  global remote byte address
- desc_num_bytes_i  in  12  transfer length in bytes
- desc_push_not_pull_i  in  1  1 = push, 0 = pull
- desc_rd_id_i  in  5  response match register id
- desc_wb_addr_i  in  12  write-back byte address
- desc_tag_i  in  tag_width_p  job tag
- halt_i  in  1  when high, no new descriptor is dequeued
- cfg_v_o  out  1  engine register write valid
- cfg_addr_o  out  5  engine register byte offset
- cfg_data_o  out  32  engine register write data
- cfg_ready_i  in  1  engine accepts the write this cycle
- dma_done_i  in  1  engine idle: all local and all remote requests sent (level)
- cmpl_v_o  out  1  one-cycle completion pulse
- cmpl_tag_o  out  tag_width_p  tag of the completed job
- cmpl_err_o  out  1  job aborted by watchdog
- busy_o  out  1  FSM not in IDLE
- pending_o  out  $clog2(els_p)+1  descriptors queued, excluding the active job

Behaviour:
- Reset: asynchronous assert and synchronous deassert, effective immediately. Reset empties the queue and returns the FSM to IDLE. All outputs reset to 0, except desc_ready_o, which is 1.
- Reset mid-job abandons the job with no completion; the engine is not otherwise touched.
- Enqueue: a descriptor is written when desc_v_i & desc_ready_o.
  - Full queue: desc_ready_o = 0 and the descriptor is held off, never dropped.
  - Simultaneous enqueue and dequeue when full is not allowed: ready is computed from registered count only.
- pending_o is the registered occupancy. It updates the cycle after each enqueue or dequeue; a simultaneous enqueue and dequeue leaves it unchanged.
- FSM states: IDLE, WR_LOC, WR_REM, WR_LEN, WR_CTL, BUSY, DONE.
- IDLE: if the queue is non-empty and halt_i = 0, pop the head into an active register.
  - num_bytes = 0 → go to DONE with no engine writes.
  - Otherwise → go to WR_LOC.
- WR_* states: cfg_v_o = 1 for the whole state. Advance only on cfg_v_o & cfg_ready_i. cfg_addr_o and cfg_data_o stay stable while stalled.
  - WR_LOC: addr 0x00, data {20'b0, local_addr}.
  - WR_REM: addr 0x04, data remote_addr.
  - WR_LEN: addr 0x08, data {20'b0, num_bytes}.
  - WR_CTL: addr 0x0C, data {4'b0, wb_addr[11:0] at [27:16], 7'b0, rd_id at [8:4], 1'b0, push_not_pull at [2], 1'b0, go=1 at [0]}. When accepted → BUSY.
  - Minimum programming time is 4 cycles.
- BUSY: on entry, a 2-bit blanking counter loads 2 and decrements each cycle. dma_done_i is ignored while the counter is nonzero, which masks a stale done level from the previous job. When the counter is 0 and dma_done_i = 1 → DONE.
- DONE: cmpl_v_o = 1 for exactly one cycle, with cmpl_tag_o = active tag and cmpl_err_o as recorded. Next state is IDLE.
  - Back-to-back jobs: the next pop occurs in the IDLE cycle, so at least one cycle separates completion from the next WR_LOC.
- halt_i affects only IDLE. A job already popped runs to completion.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: VANILLA_DMA_SCHED_WATCHDOG_EN.
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle.
  - When it reaches timeout_cycles_p-1 without done → DONE with cmpl_err_o = 1.
  - Normal completion gives cmpl_err_o = 0.
- Undefined: no counter is built, cmpl_err_o is tied to 0, and BUSY waits indefinitely.

Test Plan:
- Single push job (local 0x100, remote 0x2000_0040, len 64, rd_id 10, wb 0x3FC, tag 5); cfg_ready_i = 1, done 20 cycles after go → writes, in consecutive cycles:
  - 0x00 / 0x0000_0100
  - 0x04 / 0x2000_0040
  - 0x08 / 0x0000_0040
  - 0x0C / 0x03FC_00A5
  - then one cmpl_v_o pulse with tag 5, err 0.
- Enqueue 5 descriptors while FSM is held by halt_i = 1, els_p = 4 → desc_ready_o drops after 4 and pending_o = 4. Release halt → completions arrive with tags in enqueue order.
- cfg_ready_i toggling 0/1 each cycle → each write held stable until accepted; exactly 4 writes per job.
- dma_done_i stuck high across two jobs → each BUSY lasts ≥ 2 cycles; no completion occurs before the 0x0C write is accepted.
- num_bytes = 0 with tag 3 → no cfg_v_o, cmpl_v_o pulse 2 cycles after enqueue.
- Watchdog enabled, timeout_cycles_p = 16, done never asserted → cmpl_err_o = 1 exactly 16 cycles after BUSY entry. Additionally, reset_n_i pulsed low mid-BUSY → all outputs 0 (desc_ready_o 1) asynchronously, and pending_o = 0.
